// File: rtl/mult_err_sweep_ctrl.sv
// Exhaustive error sweep of an approximate multiplier against the exact one:
// steps every (x,y) pair through a 2-stage pipeline and accumulates error metrics.

module top_exact #(
   parameter int Bitwidth = 8
) (
   input  logic [Bitwidth-1:0]   a,
   input  logic [Bitwidth-1:0]   b,
   output logic [2*Bitwidth-1:0] p
);
   assign p = {{Bitwidth{1'b0}}, a} * {{Bitwidth{1'b0}}, b};
endmodule

// Truncated multiplier: partial-product bits of column weight below Bitwidth-1 are dropped.
module top_approx2 #(
   parameter int Bitwidth = 8
) (
   input  logic [Bitwidth-1:0]   a,
   input  logic [Bitwidth-1:0]   b,
   output logic [2*Bitwidth-1:0] p
);
   always_comb begin
      p = '0;
      for (int j = 0; j < Bitwidth; j++)
         for (int i = 0; i < Bitwidth; i++)
            if ((i + j >= Bitwidth - 1) && a[i] && b[j])
               p = p + ((2*Bitwidth)'(1) << (i + j));
   end
endmodule

module mult_err_sweep_ctrl #(
   parameter int Bitwidth   = 8,
   parameter int APPROX_SEL = 2,
   parameter int ACC_W      = 4*Bitwidth
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  metrics_valid,
   output logic [2*Bitwidth:0]   pair_count,
   output logic [2*Bitwidth:0]   err_count,
   output logic [ACC_W-1:0]      sum_ed,
   output logic [2*Bitwidth-1:0] max_ed
);
   localparam int PW = 2*Bitwidth;
   localparam int CW = 2*Bitwidth + 1;
   localparam logic [PW-1:0] PENULT = {{(PW-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   op_q, op_d;      // {x, y}: y is the inner loop
   logic            v0_q, v0_d, v1_q, v1_d;
   logic [PW-1:0]   ex_q, ex_d, ap_q, ap_d;
   logic [PW-1:0]   exact_w, approx_w;
   logic            busy_q, busy_d, done_q, done_d, mv_q, mv_d;
   logic [CW-1:0]   pc_q, pc_d, ec_q, ec_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [PW-1:0]   max_q, max_d;
   logic [CW-1:0]   diff, neg;
   logic [PW-1:0]   ed;
   logic            acc_en;

   top_exact #(.Bitwidth(Bitwidth)) u_exact (
      .a(op_q[PW-1:Bitwidth]), .b(op_q[Bitwidth-1:0]), .p(exact_w));

   generate
      if (APPROX_SEL == 2) begin : g_approx2
         top_approx2 #(.Bitwidth(Bitwidth)) u_dut (
            .a(op_q[PW-1:Bitwidth]), .b(op_q[Bitwidth-1:0]), .p(approx_w));
      end else begin : g_self
         top_exact #(.Bitwidth(Bitwidth)) u_dut (
            .a(op_q[PW-1:Bitwidth]), .b(op_q[Bitwidth-1:0]), .p(approx_w));
      end
   endgenerate

   // Subtract one bit wider so the sign survives, then take the magnitude.
   assign diff = {1'b0, ex_q} - {1'b0, ap_q};
   assign neg  = ~diff + CW'(1);
   assign ed   = diff[PW] ? neg[PW-1:0] : diff[PW-1:0];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      v0_d    = v0_q;
      v1_d    = v0_q;
      ex_d    = exact_w;
      ap_d    = approx_w;
      acc_en  = v1_q;
      pc_d    = pc_q;
      ec_d    = ec_q;
      sum_d   = sum_q;
      max_d   = max_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               op_d    = '0;
               v0_d    = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               op_d    = '0;
               v0_d    = 1'b0;
               v1_d    = 1'b0;
               acc_en  = 1'b0;
            end else begin
               op_d = op_q + PW'(1);
               if (op_q == PENULT) state_d = DRAIN;
            end
         end
         DRAIN: begin
            op_d = '0;
            v0_d = 1'b0;
            if (abort) begin
               state_d = IDLE;
               v1_d    = 1'b0;
               acc_en  = 1'b0;
            end else if (!v0_q) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (acc_en) begin
         pc_d  = pc_q + CW'(1);
         ec_d  = ec_q + {{(CW-1){1'b0}}, (ed != '0)};
         sum_d = sum_q + {{(ACC_W-PW){1'b0}}, ed};
         if (ed > max_q) max_d = ed;
      end
      // A fresh sweep starts from clean metrics on the start edge itself.
      if ((state_q == IDLE || state_q == DONE) && start) begin
         pc_d  = '0;
         ec_d  = '0;
         sum_d = '0;
         max_d = '0;
      end

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE) && (state_q != DONE);
      mv_d   = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         ex_q    <= '0;
         ap_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mv_q    <= 1'b0;
         pc_q    <= '0;
         ec_q    <= '0;
         sum_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         ex_q    <= ex_d;
         ap_q    <= ap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mv_q    <= mv_d;
         pc_q    <= pc_d;
         ec_q    <= ec_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign metrics_valid = mv_q;
   assign pair_count    = pc_q;
   assign err_count     = ec_q;
   assign sum_ed        = sum_q;
   assign max_ed        = max_q;
endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Bench for mult_err_sweep_ctrl at Bitwidth=4: self-check (APPROX_SEL=0) and
// truncated-multiplier (APPROX_SEL=2) instances driven in lock-step against a timeline model.

module tb_mult_err_sweep_ctrl;
   localparam int B = 4;
   localparam int N = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;

   logic       busy0, done0, mv0, busy2, done2, mv2;
   logic [8:0] pc0, ec0, pc2, ec2;
   logic [15:0] sum0, sum2;
   logic [7:0] max0, max2;

   int checks = 0;
   int failures = 0;

   mult_err_sweep_ctrl #(.Bitwidth(B), .APPROX_SEL(0), .ACC_W(4*B)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy0), .done(done0), .metrics_valid(mv0),
      .pair_count(pc0), .err_count(ec0), .sum_ed(sum0), .max_ed(max0));

   mult_err_sweep_ctrl #(.Bitwidth(B), .APPROX_SEL(2), .ACC_W(4*B)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy2), .done(done2), .metrics_valid(mv2),
      .pair_count(pc2), .err_count(ec2), .sum_ed(sum2), .max_ed(max2));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Golden truncated multiplier: keep only bit products a[i]*b[j] with i+j >= B-1.
   function automatic int approx_m(input int x, input int y);
      int p = 0;
      for (int i = 0; i < B; i++)
         for (int j = 0; j < B; j++)
            if (i + j >= B - 1) p += ((x >> i) & 1) * ((y >> j) & 1) * (1 << (i + j));
      return p;
   endfunction

   // Metrics after the first k pairs of the sweep order.
   int cum_err[0:N];
   int cum_sum[0:N];
   int cum_max[0:N];

   // Timeline model: phase 0 idle (holds m_k pairs), 1 sweeping (m_t edges since start), 2 done.
   int m_phase = 0;
   int m_t = 0;
   int m_k = 0;
   bit m_first = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_k     <= 0;
         m_t     <= 0;
         m_first <= 1'b0;
      end else begin
         m_first <= 1'b0;
         if (m_phase != 1) begin
            if (start) begin
               m_phase <= 1;
               m_t     <= 0;
            end
         end else if (abort) begin
            m_phase <= 0;
            m_k     <= (m_t > 0) ? m_t - 1 : 0;
         end else if (m_t == N) begin
            m_phase <= 2;
            m_first <= 1'b1;
         end else begin
            m_t <= m_t + 1;
         end
      end
   end

   always @(negedge clk) begin
      int k;
      bit eb, ed, ev;
      if (m_phase == 1) k = (m_t > 0) ? m_t - 1 : 0;
      else if (m_phase == 2) k = N;
      else k = m_k;
      eb = (m_phase == 1);
      ed = (m_phase == 2) && m_first;
      ev = (m_phase == 2);
      chk("busy0", busy0, eb);
      chk("done0", done0, ed);
      chk("valid0", mv0, ev);
      chk("pairs0", pc0, k);
      chk("err0", ec0, 0);
      chk("sum0", sum0, 0);
      chk("max0", max0, 0);
      chk("busy2", busy2, eb);
      chk("done2", done2, ed);
      chk("valid2", mv2, ev);
      chk("pairs2", pc2, k);
      chk("err2", ec2, cum_err[k]);
      chk("sum2", sum2, cum_sum[k]);
      chk("max2", max2, cum_max[k]);
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Counts edges from the start edge (base edges already elapsed) until done is seen.
   task automatic wait_done(input int base, output int edge_at);
      int e = base;
      edge_at = -1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         e++;
         #1;
         if (done2) begin
            edge_at = e;
            break;
         end
      end
   endtask

   task automatic final_checks(input string tag);
      chk({tag, "_pairs0"}, pc0, 256);
      chk({tag, "_err0"}, ec0, 0);
      chk({tag, "_sum0"}, sum0, 0);
      chk({tag, "_max0"}, max0, 0);
      chk({tag, "_pairs2"}, pc2, 256);
      chk({tag, "_max2"}, max2, 17);
      chk({tag, "_err2"}, ec2, cum_err[N]);
      chk({tag, "_sum2"}, sum2, cum_sum[N]);
      chk({tag, "_valid"}, mv2, 1);
   endtask

   initial begin
      int ea, e, s, mx;
      s = 0; e = 0; mx = 0;
      for (int k = 0; k < N; k++) begin
         int x, y, ex, d;
         x = k >> B;
         y = k % (1 << B);
         ex = x * y;
         d = ex - approx_m(x, y);
         if (d < 0) d = -d;
         cum_err[k] = e; cum_sum[k] = s; cum_max[k] = mx;
         if (d != 0) e++;
         s += d;
         if (d > mx) mx = d;
      end
      cum_err[N] = e; cum_sum[N] = s; cum_max[N] = mx;

      // Hand-computed pins of the golden multiplier.
      chk("pin_approx_15x15", approx_m(15, 15), 208);
      chk("pin_approx_3x3", approx_m(3, 3), 0);
      chk("pin_approx_8x1", approx_m(8, 1), 8);
      chk("pin_approx_7x7", approx_m(7, 7), 32);
      chk("pin_max_ed", cum_max[N], 17);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Reset in the middle of a sweep
      pulse_start();
      repeat (50) @(posedge clk);
      #2;
      chk("pre_reset_busy", busy2, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy2, 0);
      chk("rst_pairs", pc2, 0);
      chk("rst_sum", sum2, 0);
      chk("rst_max", max2, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Full sweep: both instances
      pulse_start();
      wait_done(0, ea);
      chk("done_edge_sweep", ea, 257);
      final_checks("sweep");
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_in_done_valid", mv2, 1);

      // Start re-pulsed during RUN
      pulse_start();
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (189) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(200, ea);
      chk("done_edge_restart_ignored", ea, 257);
      final_checks("reign");

      // Abort at edge 100, then a clean sweep
      pulse_start();
      repeat (99) @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_busy", busy2, 0);
      chk("abort_pairs", pc2, 98);
      chk("abort_valid", mv2, 0);
      chk("abort_done", done2, 0);
      repeat (5) @(negedge clk);
      chk("abort_hold_pairs", pc0, 98);
      pulse_start();
      wait_done(0, ea);
      chk("done_edge_after_abort", ea, 257);
      final_checks("post_abort");

      // Start held high while in DONE
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("restart_cleared", pc2, 0);
      chk("restart_valid", mv2, 0);
      chk("restart_busy", busy2, 1);
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(2, ea);
      chk("done_edge_held_start", ea, 257);
      final_checks("held");
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
